// File: rtl/tim_counter_pkg.sv
// Shared types and default constants for the Morse pulse-duration timer.
package tim_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WID_D     = 32;
  localparam int NSLOT_D   = 5;
  localparam int GAP_MAX_D = 30;
  localparam int MIN_GAP_D = 2;
  localparam int SLOT_W    = 3;

endpackage

// File: rtl/tim_counter_reg_n.sv
// Generic N-bit storage register with write enable and active-low async clear.
module reg_n #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/tim_counter.sv
// Morse pulse-duration timer: times each key-down pulse, records up to NSLOT of them
// and flags end-of-message after a long gap. Optional min-gap check: TIM_COUNTER_MIN_GAP_EN.
module tim_counter
  import tim_counter_pkg::*;
#(
  parameter int WID     = WID_D,
  parameter int NSLOT   = NSLOT_D,
  parameter int GAP_MAX = GAP_MAX_D
`ifdef TIM_COUNTER_MIN_GAP_EN
  , parameter int MIN_GAP = MIN_GAP_D
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig_in,
  output logic [WID-1:0]        ct,
  output logic [NSLOT*WID-1:0]  value,
  output logic [SLOT_W-1:0]     slot_ct,
  output logic                  m_end,
  output logic                  valid
);

  localparam logic [WID-1:0]    GAP_LIM   = WID'(GAP_MAX);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);
`ifdef TIM_COUNTER_MIN_GAP_EN
  localparam logic [WID-1:0]    MIN_LIM   = WID'(MIN_GAP);
`endif

  state_e              state_q, state_d;
  logic [WID-1:0]      ct_q, ct_d;
  logic [SLOT_W-1:0]   slotCt_q, slotCt_d;
  logic                ovf_q, ovf_d;
  logic                mEnd_q, mEnd_d;
  logic                valid_q, valid_d;
  logic                sigPrev_q;
  logic                errFlag;
  logic                rise, fall;
  logic                capStrobe;
  logic [WID-1:0]      ctInc;
  logic                resetN;

  assign rise   = sig_in & ~sigPrev_q;
  assign fall   = ~sig_in & sigPrev_q;
  // Saturating increment doubles as the capture value, so ct+1 equals the pulse length.
  assign ctInc  = (ct_q == '1) ? ct_q : ct_q + 1'b1;
  assign resetN = ~reset;

`ifdef TIM_COUNTER_MIN_GAP_EN
  logic err_q, err_d;
  assign errFlag = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign errFlag = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ct_q      <= '0;
      slotCt_q  <= '0;
      ovf_q     <= 1'b0;
      mEnd_q    <= 1'b0;
      valid_q   <= 1'b0;
      sigPrev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ct_q      <= ct_d;
      slotCt_q  <= slotCt_d;
      ovf_q     <= ovf_d;
      mEnd_q    <= mEnd_d;
      valid_q   <= valid_d;
      sigPrev_q <= sig_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    ct_d      = ct_q;
    slotCt_d  = slotCt_q;
    ovf_d     = ovf_q;
    mEnd_d    = mEnd_q;
    valid_d   = valid_q;
    capStrobe = 1'b0;
`ifdef TIM_COUNTER_MIN_GAP_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          ct_d    = '0;
          state_d = MARK;
        end
      end
      MARK: begin
        if (fall) begin
          capStrobe = 1'b1;
          ct_d      = '0;
          state_d   = SPACE;
        end else begin
          ct_d = ctInc;
        end
      end
      SPACE: begin
        // A new pulse wins over the gap timeout when both land on the same edge.
        if (rise) begin
          if (slotCt_q < LAST_SLOT) begin
            slotCt_d = slotCt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
`ifdef TIM_COUNTER_MIN_GAP_EN
          if (ct_q < MIN_LIM) begin
            err_d = 1'b1;
          end
`endif
          ct_d    = '0;
          state_d = MARK;
        end else begin
          ct_d = ctInc;
          if (ct_q > GAP_LIM) begin
            state_d = DONE;
            mEnd_d  = 1'b1;
            valid_d = ~ovf_q & ~errFlag;
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pulses beyond the last slot are timed but never stored.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    reg_n #(.N(WID)) u_slot (
      .clk_i  (clk),
      .rst_ni (resetN),
      .en_i   (capStrobe && (slotCt_q == SLOT_W'(i)) && !ovf_q),
      .d_i    (ctInc),
      .q_o    (value[WID*i +: WID])
    );
  end

  assign ct      = ct_q;
  assign slot_ct = slotCt_q;
  assign m_end   = mEnd_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_tim_counter.sv
// Scoreboard bench for tim_counter: each message's expected outcome is derived from
// run lengths of the key waveform and checked when m_end rises. Honors TIM_COUNTER_MIN_GAP_EN.
module tb_tim_counter;

  localparam int WID     = 32;
  localparam int NSLOT   = 5;
  localparam int GAP_MAX = 30;
  localparam int MIN_GAP = 2;
  localparam int TAIL    = 40;

  typedef struct packed {
    int                   endEdge;
    logic [NSLOT*WID-1:0] slots;
    logic [2:0]           slotCt;
    logic                 vld;
  } expT;

  logic                 clk    = 1'b0;
  logic                 reset  = 1'b1;
  logic                 sig_in = 1'b0;
  logic [WID-1:0]       ct;
  logic [NSLOT*WID-1:0] value;
  logic [2:0]           slot_ct;
  logic                 m_end;
  logic                 valid;

  int   checks  = 0;
  int   errors  = 0;
  int   cycleNo = 0;
  expT  expQ[$];
  expT  lastExp;
  expT  monExp;
  bit   stimBits[$];
  logic mendPrev = 1'b0;

  tim_counter dut (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (sig_in),
    .ct      (ct),
    .value   (value),
    .slot_ct (slot_ct),
    .m_end   (m_end),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkSlots(input string tag, input logic [NSLOT*WID-1:0] expSlots);
    for (int k = 0; k < NSLOT; k++)
      checkOutput($sformatf("%s slot%0d", tag, k), value[k*WID +: WID], expSlots[k*WID +: WID]);
  endtask

  // Reference: pulses are runs of 1s, gaps runs of 0s. The counter is cleared on the
  // falling sample and must exceed GAP_MAX without a rise, i.e. GAP_MAX+2 edges later.
  function automatic expT modelMessage(input int startEdge);
    expT e;
    int  n, i, pulses, runStart, lowStart, lowLen;
    bit  err;
    e = '0;
    e.endEdge = -1;
    n = stimBits.size();
    i = 0;
    pulses = 0;
    err = 1'b0;
    while (i < n && !stimBits[i]) i++;
    while (i < n) begin
      runStart = i;
      while (i < n && stimBits[i]) i++;
      if (pulses < NSLOT) e.slots[pulses*WID +: WID] = WID'(i - runStart);
      pulses++;
      lowStart = i;
      while (i < n && !stimBits[i]) i++;
      lowLen = i - lowStart;
      if (lowLen >= GAP_MAX + 3) begin
        e.endEdge = startEdge + lowStart + GAP_MAX + 2;
        break;
      end
      if (i < n && lowLen < MIN_GAP + 1) err = 1'b1;
    end
    e.slotCt = 3'(((pulses < NSLOT) ? pulses : NSLOT) - 1);
`ifdef TIM_COUNTER_MIN_GAP_EN
    e.vld = (pulses <= NSLOT) && !err;
`else
    e.vld = (pulses <= NSLOT);
`endif
    return e;
  endfunction

  task automatic addLevel(input bit lvl, input int len);
    for (int k = 0; k < len; k++) stimBits.push_back(lvl);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset  = 1'b1;
    sig_in = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  // Caller is at a negedge with reset low; sample i is taken at edge cycleNo+1+i.
  task automatic applyStimulus();
    lastExp = modelMessage(cycleNo + 1);
    expQ.push_back(lastExp);
    foreach (stimBits[i]) begin
      sig_in = stimBits[i];
      @(negedge clk);
    end
    sig_in = 1'b0;
    for (int w = 0; w < 100 && expQ.size() != 0; w++) @(negedge clk);
    checkOutput("queue drained", expQ.size(), 0);
    checkOutput("m_end held", m_end, 1);
    checkOutput("valid held", valid, lastExp.vld);
    checkSlots("held", lastExp.slots);
  endtask

  always @(negedge clk) begin
    if (!reset && m_end && !mendPrev) begin
      if (expQ.size() == 0) begin
        checkOutput("m_end without expectation", expQ.size(), 1);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("m_end edge", cycleNo, monExp.endEdge);
        checkOutput("ct at end", ct, GAP_MAX + 2);
        checkOutput("slot_ct", slot_ct, monExp.slotCt);
        checkOutput("valid", valid, monExp.vld);
        checkSlots("end", monExp.slots);
      end
    end
    mendPrev <= m_end;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int np;

    // Idle after reset
    doReset();
    repeat (50) @(negedge clk);
    checkOutput("idle ct", ct, 0);
    checkOutput("idle value", value, 0);
    checkOutput("idle slot_ct", slot_ct, 0);
    checkOutput("idle m_end", m_end, 0);
    checkOutput("idle valid", valid, 0);

    // 3 high, 5 low, 9 high, long gap
    stimBits.delete();
    addLevel(1, 3); addLevel(0, 5); addLevel(1, 9); addLevel(0, TAIL);
    doReset(); applyStimulus();

    // Six pulses: overflow
    stimBits.delete();
    for (int p = 0; p < 6; p++) begin addLevel(1, 2); addLevel(0, 4); end
    addLevel(0, TAIL);
    doReset(); applyStimulus();

    // Exactly NSLOT pulses
    stimBits.delete();
    for (int p = 0; p < NSLOT; p++) begin addLevel(1, p + 1); addLevel(0, 2); end
    addLevel(0, TAIL);
    doReset(); applyStimulus();

    // Gap lengths around the timeout boundary, then a pulse that DONE must ignore
    stimBits.delete();
    addLevel(1, 2); addLevel(0, 30);
    addLevel(1, 3); addLevel(0, 31);
    addLevel(1, 4); addLevel(0, 32);
    addLevel(1, 5); addLevel(0, 33);
    addLevel(1, 6); addLevel(0, TAIL);
    doReset(); applyStimulus();

    // One-cycle gap between pulses
    stimBits.delete();
    addLevel(1, 4); addLevel(0, 1); addLevel(1, 4); addLevel(0, TAIL);
    doReset(); applyStimulus();

    // Reset asserted part-way through a pulse, released with the key still down
    doReset();
    sig_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid-pulse ct", ct, 4);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async ct", ct, 0);
    checkOutput("async value", value, 0);
    checkOutput("async slot_ct", slot_ct, 0);
    checkOutput("async m_end", m_end, 0);
    checkOutput("async valid", valid, 0);
    @(negedge clk);
    reset = 1'b0;
    stimBits.delete();
    addLevel(1, 5); addLevel(0, TAIL);
    applyStimulus();

    // Randomized messages
    for (int m = 0; m < 25; m++) begin
      np = $urandom_range(1, 7);
      stimBits.delete();
      addLevel(0, $urandom_range(0, 5));
      for (int p = 0; p < np; p++) begin
        addLevel(1, $urandom_range(1, 12));
        if (p < np - 1) addLevel(0, $urandom_range(1, 36));
      end
      addLevel(0, TAIL);
      doReset(); applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
